// File: rtl/run_ctrl_pkg.sv
// Shared state encoding and default parameters for the run_ctrl sequencer.
// The state values are fixed localparams so existing logic-analyser decodes stay valid.
package run_ctrl_pkg;

    localparam int AW_DEF       = 8;
    localparam int DW_DEF       = 8;
    localparam int LD_BASE_DEF  = 0;
    localparam int N_LD_DEF     = 64;
    localparam int RES_BASE_DEF = 64;
    localparam int N_RES_DEF    = 32;
    localparam int TMO_CYC_DEF  = 4096;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD   = 3'd1;
    localparam logic [2:0] ST_REQ    = 3'd2;
    localparam logic [2:0] ST_WAIT   = 3'd3;
    localparam logic [2:0] ST_UNLOAD = 3'd4;
    localparam logic [2:0] ST_FIN    = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_LOAD   = ST_LOAD,
        S_REQ    = ST_REQ,
        S_WAIT   = ST_WAIT,
        S_UNLOAD = ST_UNLOAD,
        S_FIN    = ST_FIN
    } state_e;

    // Bits needed to hold a count from 0 up to and including n.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/run_tmo_cnt.sv
// Clearable timeout counter that saturates at LIMIT.
// hit is high during the LIMIT-th consecutive enabled cycle (and beyond, if ever held).
module run_tmo_cnt
    import run_ctrl_pkg::*;
#(
    parameter int LIMIT = TMO_CYC_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic hit
);

    localparam int CW = cnt_width(LIMIT);

    logic [CW-1:0] cnt;

    // NOTE: sequential state is always written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            cnt <= '0;
        end else if (en && (cnt != CW'(LIMIT))) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign hit = en && (cnt >= CW'(LIMIT - 1));

endmodule

// File: rtl/run_ctrl.sv
// Run sequencer: load words into data memory, request the core, wait for done, unload results.
// Define RUN_CTRL_TIMEOUT_EN to add the WAIT timeout counter and the err flag.
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int AW       = AW_DEF,
    parameter int DW       = DW_DEF,
    parameter int LD_BASE  = LD_BASE_DEF,
    parameter int N_LD     = N_LD_DEF,
    parameter int RES_BASE = RES_BASE_DEF,
    parameter int N_RES    = N_RES_DEF,
    parameter int TMO_CYC  = TMO_CYC_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          ld_valid,
    output logic          ld_ready,
    input  logic [DW-1:0] ld_data,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [DW-1:0] res_data,
    output logic          core_rst,
    output logic          req,
    input  logic          done,
    output logic          mem_wr_en,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdat,
    input  logic [DW-1:0] mem_rdat,
    output logic          busy,
    output logic          err
);

    // One extra bit so a run of 2^AW words can still be counted.
    localparam int CW = AW + 1;

    state_e        state;
    logic [CW-1:0] k;
    logic [CW-1:0] j;
    logic          timeout;
    logic          ld_xfer;
    logic          res_xfer;

    // NOTE: outputs are gated by reset so they show reset values during the reset cycle itself,
    // not only after the synchronous reset has been sampled.
    assign busy      = reset && (state != S_IDLE);
    assign core_rst  = !reset || (state == S_IDLE) || (state == S_LOAD);
    assign req       = reset && ((state == S_REQ) || (state == S_WAIT));
    assign ld_ready  = reset && (state == S_LOAD);
    assign res_valid = reset && (state == S_UNLOAD);

    assign ld_xfer   = ld_ready && ld_valid;
    assign res_xfer  = res_valid && res_ready;

    assign mem_wr_en = ld_xfer;
    assign mem_wdat  = ld_data;
    assign mem_addr  = (state == S_UNLOAD) ? AW'(RES_BASE) + j[AW-1:0]
                                           : AW'(LD_BASE) + k[AW-1:0];
    // Read data is combinational from mem_addr, and j only moves on a transfer.
    assign res_data  = mem_rdat;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_IDLE;
            k     <= '0;
            j     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_LOAD;
                        k     <= '0;
                    end
                end
                S_LOAD: begin
                    if (ld_xfer) begin
                        if (k == CW'(N_LD - 1)) begin
                            state <= S_REQ;
                            k     <= '0;
                        end else begin
                            k <= k + CW'(1);
                        end
                    end
                end
                S_REQ: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    // done takes priority over a timeout in the same cycle.
                    if (done) begin
                        state <= S_UNLOAD;
                        j     <= '0;
                    end else if (timeout) begin
                        state <= S_FIN;
                    end
                end
                S_UNLOAD: begin
                    if (res_xfer) begin
                        if (j == CW'(N_RES - 1)) begin
                            state <= S_FIN;
                            j     <= '0;
                        end else begin
                            j <= j + CW'(1);
                        end
                    end
                end
                S_FIN: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef RUN_CTRL_TIMEOUT_EN
    logic err_q;

    run_tmo_cnt #(
        .LIMIT (TMO_CYC)
    ) u_tmo (
        .clk   (clk),
        .reset (reset),
        .clear (state != S_WAIT),
        .en    (state == S_WAIT),
        .hit   (timeout)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else if ((state == S_IDLE) && start) begin
            err_q <= 1'b0;
        end else if ((state == S_WAIT) && !done && timeout) begin
            err_q <= 1'b1;
        end
    end

    assign err = reset && err_q;
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_run_ctrl.sv
// Directed bench for run_ctrl: default instance for run/backpressure/timeout/reset,
// plus a small wrap-around instance (LD_BASE=250, N_LD=10, RES_BASE=255, N_RES=2).
module tb_run_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       start2;
    logic       ld_valid;
    logic [7:0] ld_data;
    logic       res_ready;
    logic       done;

    logic       ld_ready, res_valid, core_rst, req, mem_wr_en, busy, err;
    logic [7:0] res_data, mem_addr, mem_wdat, mem_rdat;

    logic       ld_ready_w, res_valid_w, core_rst_w, req_w, mem_wr_en_w, busy_w, err_w;
    logic [7:0] res_data_w, mem_addr_w, mem_wdat_w, mem_rdat_w;

    always #5 clk = ~clk;

    // Results preloaded at 64..95 hold 0xA0..0xBF; everything else reads 0xEE.
    assign mem_rdat   = (mem_addr >= 8'd64 && mem_addr < 8'd96) ? mem_addr + 8'h60 : 8'hEE;
    assign mem_rdat_w = mem_addr_w ^ 8'h5A;

    run_ctrl dut (
        .clk(clk), .reset(reset), .start(start),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .core_rst(core_rst), .req(req), .done(done),
        .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wdat(mem_wdat), .mem_rdat(mem_rdat),
        .busy(busy), .err(err)
    );

    run_ctrl #(
        .LD_BASE(250), .N_LD(10), .RES_BASE(255), .N_RES(2), .TMO_CYC(16)
    ) dut_w (
        .clk(clk), .reset(reset), .start(start2),
        .ld_valid(ld_valid), .ld_ready(ld_ready_w), .ld_data(ld_data),
        .res_valid(res_valid_w), .res_ready(res_ready), .res_data(res_data_w),
        .core_rst(core_rst_w), .req(req_w), .done(done),
        .mem_wr_en(mem_wr_en_w), .mem_addr(mem_addr_w), .mem_wdat(mem_wdat_w), .mem_rdat(mem_rdat_w),
        .busy(busy_w), .err(err_w)
    );

    int checks   = 0;
    int failures = 0;

    logic [7:0] wr_addr [256];
    logic [7:0] wr_dat  [256];
    logic [7:0] res_got [64];
    int         n_wr, n_res, req_cycles, stall_bad;
    bit         res_seen, run_open;
    logic       err_first;

    int wexp [10] = '{250, 251, 252, 253, 254, 255, 0, 1, 2, 3};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One run on the default instance, called at a negedge. done rises once req has been
    // seen for more than done_dly cycles (never if done_dly < 0); abort_at >= 0 pulses
    // reset while the result with that index is being offered.
    task automatic run(input bit bp, input int done_dly, input int abort_at);
        int         li = 0;
        bit         prev_stall = 1'b0;
        logic [7:0] prev_data = '0;
        n_wr = 0; n_res = 0; req_cycles = 0; stall_bad = 0; res_seen = 1'b0; run_open = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 20000; cyc++) begin
            if (req) req_cycles++;
            if (core_rst) done = 1'b0;
            else if (done_dly >= 0 && req_cycles > done_dly) done = 1'b1;
            ld_valid  = bp ? (cyc % 2 == 0) : 1'b1;
            ld_data   = 8'(li);
            res_ready = bp ? (cyc % 4 == 3) : 1'b1;
            if (abort_at >= 0 && n_res == abort_at && res_valid) begin
                reset = 1'b0;
                #1;
                check("rst_busy",      32'(busy),      0);
                check("rst_err",       32'(err),       0);
                check("rst_req",       32'(req),       0);
                check("rst_core_rst",  32'(core_rst),  1);
                check("rst_ld_ready",  32'(ld_ready),  0);
                check("rst_res_valid", 32'(res_valid), 0);
                check("rst_mem_wr_en", 32'(mem_wr_en), 0);
                @(negedge clk);
                reset = 1'b1;
                #1;
                check("abort_idle_busy",      32'(busy),      0);
                check("abort_idle_res_valid", 32'(res_valid), 0);
                check("abort_idle_core_rst",  32'(core_rst),  1);
                return;
            end
            #1;
            if (cyc == 0) err_first = err;
            if (prev_stall && res_data !== prev_data) stall_bad++;
            if (mem_wr_en && n_wr < 256) begin
                wr_addr[n_wr] = mem_addr;
                wr_dat[n_wr]  = mem_wdat;
                n_wr++;
            end
            if (ld_valid && ld_ready) li++;
            if (res_valid && res_ready && n_res < 64) begin
                res_got[n_res] = res_data;
                n_res++;
            end
            if (res_valid) res_seen = 1'b1;
            prev_stall = res_valid && !res_ready;
            prev_data  = res_data;
            if (!busy) begin
                run_open = 1'b0;
                break;
            end
            @(negedge clk);
        end
        check("run_finished", 32'(run_open), 0);
    endtask

    task automatic check_std(input string t, input int exp_req);
        int bad_wr = 0;
        int bad_rs = 0;
        for (int i = 0; i < n_wr; i++)
            if (wr_addr[i] !== 8'(i) || wr_dat[i] !== 8'(i)) bad_wr++;
        for (int i = 0; i < n_res; i++)
            if (res_got[i] !== 8'(32'hA0 + i)) bad_rs++;
        check({t, "_n_wr"},      n_wr,       64);
        check({t, "_wr_order"},  bad_wr,     0);
        check({t, "_req_cyc"},   req_cycles, exp_req);
        check({t, "_n_res"},     n_res,      32);
        check({t, "_res_order"}, bad_rs,     0);
        check({t, "_stall"},     stall_bad,  0);
        check({t, "_busy"},      32'(busy),  0);
    endtask

    initial begin
        logic [7:0] w_addr [16];
        logic [7:0] w_dat  [16];
        logic [7:0] r_got  [4];
        int         n_w = 0;
        int         n_r = 0;
        int         bad = 0;
        bit         fin_pulse = 1'b0;
        bit         w_open = 1'b1;

        reset = 1'b0; start = 1'b0; start2 = 1'b0;
        ld_valid = 1'b0; ld_data = '0; res_ready = 1'b0; done = 1'b0;

        @(negedge clk);
        #1;
        check("reset_busy",      32'(busy),      0);
        check("reset_err",       32'(err),       0);
        check("reset_req",       32'(req),       0);
        check("reset_core_rst",  32'(core_rst),  1);
        check("reset_ld_ready",  32'(ld_ready),  0);
        check("reset_res_valid", 32'(res_valid), 0);
        check("reset_mem_wr_en", 32'(mem_wr_en), 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("idle_busy",     32'(busy),     0);
        check("idle_core_rst", 32'(core_rst), 1);

        // Plain run: done 100 cycles after req rises.
        run(1'b0, 100, -1);
        check_std("basic", 101);
        check("basic_err", 32'(err), 0);

        // Backpressure on both streams.
        run(1'b1, 10, -1);
        check_std("bp", 11);

`ifdef RUN_CTRL_TIMEOUT_EN
        // No done: 1 REQ cycle + 4096 WAIT cycles, then FIN with err.
        run(1'b0, -1, -1);
        check("tmo_req_cyc",   req_cycles,     4097);
        check("tmo_n_wr",      n_wr,           64);
        check("tmo_res_valid", 32'(res_seen),  0);
        check("tmo_err",       32'(err),       1);
        repeat (3) @(negedge clk);
        #1;
        check("tmo_err_held",  32'(err),       1);
        // done in the 4096th WAIT cycle wins over the timeout.
        run(1'b0, 4096, -1);
        check("tmo_err_cleared", 32'(err_first), 0);
        check_std("coin", 4097);
        check("coin_err", 32'(err), 0);
`else
        // Without the timeout WAIT holds until done, however long.
        run(1'b0, 5000, -1);
        check_std("notmo", 5001);
        check("notmo_err", 32'(err), 0);
`endif

        // Reset in the middle of the unload, then a fresh run from j=0.
        run(1'b0, 3, 5);
        check("abort_n_res", n_res, 5);
        run(1'b0, 3, -1);
        check_std("after_abort", 4);
        check("after_abort_first", 32'(res_got[0]), 32'hA0);

        // Wrap-around instance; extra start pulses land in LOAD, UNLOAD and FIN.
        done = 1'b0; ld_valid = 1'b1; res_ready = 1'b1;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        for (int c = 0; c < 60; c++) begin
            start2 = (c == 3) || (c == 13) || fin_pulse;
            fin_pulse = 1'b0;
            if (req_w) done = 1'b1;
            else if (core_rst_w) done = 1'b0;
            ld_data = 8'(32'h30 + n_w);
            #1;
            if (mem_wr_en_w && n_w < 16) begin
                w_addr[n_w] = mem_addr_w;
                w_dat[n_w]  = mem_wdat_w;
                n_w++;
            end
            if (res_valid_w && res_ready && n_r < 4) begin
                r_got[n_r] = res_data_w;
                n_r++;
                if (n_r == 2) fin_pulse = 1'b1;
            end
            if (!busy_w) begin
                w_open = 1'b0;
                break;
            end
            @(negedge clk);
        end
        start2 = 1'b0;
        check("wrap_finished", 32'(w_open), 0);
        check("wrap_n_wr", n_w, 10);
        for (int i = 0; i < n_w && i < 10; i++)
            if (w_addr[i] !== 8'(wexp[i]) || w_dat[i] !== 8'(32'h30 + i)) bad++;
        check("wrap_wr_order", bad, 0);
        check("wrap_n_res", n_r, 2);
        check("wrap_res0", 32'(r_got[0]), 32'hA5);
        check("wrap_res1", 32'(r_got[1]), 32'h5A);
        @(negedge clk);
        #1;
        check("wrap_fin_start_busy",     32'(busy_w),     0);
        check("wrap_fin_start_ld_ready", 32'(ld_ready_w), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/run_ctrl.md
RUN_CTRL -- requirements
Module: run_ctrl

Interface
REQ-001 Parameter AW, default 8, data-memory address width.
REQ-002 Parameter DW, default 8, data-memory word width.
REQ-003 Parameter LD_BASE, default 0, first memory address written during load.
REQ-004 Parameter N_LD, default 64, number of words loaded per run (1..2^AW).
REQ-005 Parameter RES_BASE, default 64, first memory address read during unload.
REQ-006 Parameter N_RES, default 32, number of words unloaded per run (1..2^AW).
REQ-007 Parameter TMO_CYC, default 4096, maximum number of core cycles to wait for done.
REQ-008 clk  in  1  single clock; all state updates on the rising edge.
REQ-009 reset  in  1  synchronous, active-low reset.
REQ-010 start  in  1  host pulse that begins a run; sampled only in IDLE.
REQ-011 ld_valid / ld_ready / ld_data  in / out / DW  load stream; a word transfers when valid and ready are both high.
REQ-012 res_valid / res_ready / res_data  out / in / DW  result stream; same transfer rule.
REQ-013 core_rst  out  1  reset to the core, active-high.
REQ-014 req  out  1  run request to the core.
REQ-015 done  in  1  core completion flag; level input.
REQ-016 mem_wr_en / mem_addr / mem_wdat  out / AW / DW  data-memory port.
REQ-017 mem_rdat  in  DW  memory read data, combinational from mem_addr in the same cycle.
REQ-018 busy / err  out / out  1 / 1  run in progress / last run timed out.

Function
REQ-019 The FSM states SHALL be IDLE, LOAD, REQ, WAIT, UNLOAD and FIN.
- IDLE: on start go to LOAD.
- LOAD: go to REQ after N_LD transfers.
- REQ: one cycle, then go to WAIT.
- WAIT: on done go to UNLOAD; on timeout go to FIN.
- UNLOAD: go to FIN after N_RES transfers.
- FIN: one cycle, then go to IDLE.
REQ-020 busy SHALL be high in every state except IDLE.
REQ-021 core_rst SHALL be high in IDLE and LOAD, so the core's done is cleared before each run; it SHALL be low from REQ through FIN.
REQ-022 In LOAD, ld_ready SHALL be high; on each transfer: mem_wr_en=1, mem_addr=LD_BASE+k, mem_wdat=ld_data, then k increments.
REQ-023 ld_ready SHALL be low in every state other than LOAD.
REQ-024 Addresses SHALL wrap modulo 2^AW (LD_BASE+k and RES_BASE+j truncated to AW bits).
REQ-025 req SHALL be high in the REQ and WAIT states only, and SHALL drop in the cycle after done is sampled high.
REQ-026 done SHALL be ignored outside WAIT.
REQ-027 In UNLOAD, mem_addr=RES_BASE+j, res_data=mem_rdat and res_valid=1.
REQ-028 j SHALL advance only on a res_ready transfer; res_data SHALL be held stable while res_ready is low.
REQ-029 mem_wr_en SHALL be low outside LOAD transfer cycles.
REQ-030 The timeout counter SHALL count WAIT cycles and fire when the count reaches TMO_CYC; if done and timeout occur in the same cycle, done wins.
REQ-031 err SHALL be set in FIN after a timeout, cleared by the next start, and held otherwise.
REQ-032 start while busy SHALL be ignored; start in the same cycle as leaving FIN SHALL be ignored (IDLE samples start only).

Reset
REQ-033 reset low SHALL force IDLE from any state, including mid-transfer, with k=j=0 and counters cleared.
REQ-034 During reset: busy=0, err=0, req=0, core_rst=1, ld_ready=0, res_valid=0, mem_wr_en=0.

Configuration
REQ-035 With RUN_CTRL_TIMEOUT_EN defined, the timeout counter, REQ-030 and err SHALL be present.
REQ-036 Without RUN_CTRL_TIMEOUT_EN, WAIT SHALL exit only on done and err SHALL be tied to 0.

Structure
REQ-037 A shared package run_ctrl_pkg SHALL hold the state enum type and the default parameter constants.
REQ-038 One sub-module, run_tmo_cnt, SHALL implement the clearable, saturating timeout counter.

Verification
REQ-039 Load-run-unload: start, then 64 words 0x00..0x3F; done after 100 cycles; memory preloaded at 64..95 with 0xA0..0xBF -> writes land at addr 0..63, req high 101 cycles, res stream 0xA0..0xBF, err=0.
REQ-040 Backpressure: ld_valid toggling every cycle and res_ready low for 3 of every 4 cycles -> no lost, duplicated or reordered words; res_data stable while stalled.
REQ-041 Timeout: done never asserted -> FIN after exactly 4096 WAIT cycles, err=1, no res_valid; the next start clears err.
REQ-042 Coincidence: done asserted in the 4096th WAIT cycle -> UNLOAD entered and err=0.
REQ-043 Reset mid-UNLOAD after 5 results -> IDLE next cycle, all outputs at reset values, and a fresh run restarts at j=0.
REQ-044 Wrap: LD_BASE=250, N_LD=10 -> writes to 250..255 then 0..3; start pulsed while busy -> no effect.
